// File: rtl/window_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel window streamer.
package window_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StDone
  } state_e;

  function automatic int out_dim(input int img, input int k, input int stride, input int pad);
    return (img + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int clog2_min1(input int x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction

  // Flat bit offset of pixel (c,r,x) in an image, or element (c,kr,kc) in a window.
  function automatic int flat_bit(input int c, input int r, input int x, input int h,
                                  input int w, input int dw);
    return ((c * h + r) * w + x) * dw;
  endfunction

endpackage

// File: rtl/window_gather.sv
// Combinational window gather: picks each (c,kr,kc) element out of the frame, zero outside it.
module window_gather
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_H      = 4,
  parameter int IMG_W      = 4,
  parameter int K_H        = 2,
  parameter int K_W        = 2,
  parameter int STRIDE_H   = 1,
  parameter int STRIDE_W   = 1,
  parameter int PAD        = 0,
  parameter int ROW_W      = 1,
  parameter int COL_W      = 1
) (
  input  logic [DATA_WIDTH*CHANNELS*IMG_H*IMG_W-1:0] frame,
  input  logic [ROW_W-1:0]                           row,
  input  logic [COL_W-1:0]                           col,
  output logic [DATA_WIDTH*CHANNELS*K_H*K_W-1:0]     win_data
);

  localparam int ImgBits = DATA_WIDTH * CHANNELS * IMG_H * IMG_W;
  localparam int IdxW    = clog2_min1(ImgBits);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar kr = 0; kr < K_H; kr++) begin : g_kr
      for (genvar kc = 0; kc < K_W; kc++) begin : g_kc
        localparam int WinBit = flat_bit(c, kr, kc, K_H, K_W, DATA_WIDTH);

        int                    src_r;
        int                    src_c;
        logic [DATA_WIDTH-1:0] pix;

        always_comb begin
          // Signed so that the padded border maps to negative coordinates.
          src_r = int'(row) * STRIDE_H + kr - PAD;
          src_c = int'(col) * STRIDE_W + kc - PAD;
          pix   = '0;
          if (src_r >= 0 && src_r < IMG_H && src_c >= 0 && src_c < IMG_W) begin
            pix = frame[IdxW'(flat_bit(c, src_r, src_c, IMG_H, IMG_W, DATA_WIDTH)) +: DATA_WIDTH];
          end
        end

        assign win_data[WinBit +: DATA_WIDTH] = pix;
      end
    end
  end

endmodule

// File: rtl/window_stream_mc.sv
// Multi-channel sliding-window generator: captures a frame on start and streams every
// window in raster order over a valid/ready handshake.
module window_stream_mc
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_H      = 4,
  parameter int IMG_W      = 4,
  parameter int K_H        = 2,
  parameter int K_W        = 2,
  parameter int STRIDE_H   = 1,
  parameter int STRIDE_W   = 1,
  parameter int PAD        = 0
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       start,
  input  logic [DATA_WIDTH*CHANNELS*IMG_H*IMG_W-1:0]                 image_flat,
  input  logic                                                       win_ready,
  output logic [DATA_WIDTH*CHANNELS*K_H*K_W-1:0]                     win_data,
  output logic                                                       win_valid,
  output logic [clog2_min1(out_dim(IMG_H, K_H, STRIDE_H, PAD))-1:0]  win_row,
  output logic [clog2_min1(out_dim(IMG_W, K_W, STRIDE_W, PAD))-1:0]  win_col,
  output logic                                                       win_last,
  output logic                                                       busy,
  output logic                                                       done
);

  localparam int OutH    = out_dim(IMG_H, K_H, STRIDE_H, PAD);
  localparam int OutW    = out_dim(IMG_W, K_W, STRIDE_W, PAD);
  localparam int RowW    = clog2_min1(OutH);
  localparam int ColW    = clog2_min1(OutW);
  localparam int ImgBits = DATA_WIDTH * CHANNELS * IMG_H * IMG_W;
  localparam int WinBits = DATA_WIDTH * CHANNELS * K_H * K_W;

  localparam logic [RowW-1:0] LastRow = RowW'(OutH - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(OutW - 1);

  if (STRIDE_H < 1 || STRIDE_W < 1 || IMG_H + 2 * PAD < K_H || IMG_W + 2 * PAD < K_W ||
      OutH < 1 || OutW < 1) begin : g_bad_cfg
    $error("window_stream_mc: kernel/stride/pad give an empty output");
  end

  state_e               state_q, state_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [ImgBits-1:0]   frame_q, frame_d;
  logic [WinBits-1:0]   data_q, data_d;
  logic [WinBits-1:0]   gathered;
  logic                 xfer;
  logic                 at_last;

  assign xfer    = (state_q == StEmit) && win_ready;
  assign at_last = (row_q == LastRow) && (col_q == LastCol);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    frame_d = frame_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          frame_d = image_flat;
          row_d   = '0;
          col_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (xfer) begin
          if (at_last) begin
            // Counters return to zero so IDLE/DONE present all-zero coordinates.
            row_d   = '0;
            col_d   = '0;
            state_d = StDone;
          end else if (col_q == LastCol) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gather looks at the next frame/coordinates so the window register loads with the counters.
  window_gather #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS),
    .IMG_H      (IMG_H),
    .IMG_W      (IMG_W),
    .K_H        (K_H),
    .K_W        (K_W),
    .STRIDE_H   (STRIDE_H),
    .STRIDE_W   (STRIDE_W),
    .PAD        (PAD),
    .ROW_W      (RowW),
    .COL_W      (ColW)
  ) u_gather (
    .frame    (frame_d),
    .row      (row_d),
    .col      (col_d),
    .win_data (gathered)
  );

  always_comb begin
    data_d = data_q;
    unique case (state_q)
      StIdle:  if (start) data_d = gathered;
      StEmit:  if (xfer) data_d = at_last ? '0 : gathered;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      data_q  <= data_d;
    end
  end

  assign win_valid = (state_q == StEmit);
  assign busy      = (state_q == StEmit);
  assign done      = (state_q == StDone);
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign win_data  = data_q;
  assign win_last  = win_valid && at_last;

endmodule

// File: tb/tb_window_stream_mc.sv
// Self-checking bench for window_stream_mc: three configurations against a behavioural model.
module tb_window_stream_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: default parameters.
  logic         a_start, a_ready, a_valid, a_last, a_busy, a_done;
  logic [127:0] a_img;
  logic [31:0]  a_data;
  logic [1:0]   a_row, a_col;

  // Instance B: 3x3 kernel, stride 2, pad 1.
  logic         b_start, b_ready, b_valid, b_last, b_busy, b_done;
  logic [127:0] b_img;
  logic [71:0]  b_data;
  logic [0:0]   b_row, b_col;

  // Instance C: two channels.
  logic         c_start, c_ready, c_valid, c_last, c_busy, c_done;
  logic [255:0] c_img;
  logic [63:0]  c_data;
  logic [1:0]   c_row, c_col;

  window_stream_mc u_a (
    .clk(clk), .rst(rst), .start(a_start), .image_flat(a_img), .win_ready(a_ready),
    .win_data(a_data), .win_valid(a_valid), .win_row(a_row), .win_col(a_col),
    .win_last(a_last), .busy(a_busy), .done(a_done)
  );

  window_stream_mc #(
    .K_H(3), .K_W(3), .STRIDE_H(2), .STRIDE_W(2), .PAD(1)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start), .image_flat(b_img), .win_ready(b_ready),
    .win_data(b_data), .win_valid(b_valid), .win_row(b_row), .win_col(b_col),
    .win_last(b_last), .busy(b_busy), .done(b_done)
  );

  window_stream_mc #(
    .CHANNELS(2)
  ) u_c (
    .clk(clk), .rst(rst), .start(c_start), .image_flat(c_img), .win_ready(c_ready),
    .win_data(c_data), .win_valid(c_valid), .win_row(c_row), .win_col(c_col),
    .win_last(c_last), .busy(c_busy), .done(c_done)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 4x4 image of 8-bit pixels, value base+r*4+x.
  function automatic logic [1023:0] make_img(input int base);
    logic [1023:0] v;
    logic [9:0]    i;
    v = '0;
    for (int p = 0; p < 16; p++) begin
      i = 10'(p * 8);
      v[i +: 8] = 8'(base + p);
    end
    return v;
  endfunction

  // Window at output (orow,ocol) of a 4x4xch image, square kernel k, stride s, padding pad.
  function automatic logic [255:0] model_win(input logic [1023:0] img, input int ch, input int k,
                                             input int s, input int pad, input int orow,
                                             input int ocol);
    logic [255:0] w;
    logic [9:0]   si;
    logic [7:0]   di;
    int           r;
    int           x;
    w = '0;
    for (int c = 0; c < ch; c++) begin
      for (int kr = 0; kr < k; kr++) begin
        for (int kc = 0; kc < k; kc++) begin
          r = orow * s + kr - pad;
          x = ocol * s + kc - pad;
          if (r >= 0 && r < 4 && x >= 0 && x < 4) begin
            si = 10'(((c * 4 + r) * 4 + x) * 8);
            di = 8'(((c * k + kr) * k + kc) * 8);
            w[di +: 8] = img[si +: 8];
          end
        end
      end
    end
    return w;
  endfunction

  task automatic run_a(input logic [1023:0] img, input bit stall, input bit mid_start,
                       input bit known);
    int idx;
    int cyc;
    int orow;
    int ocol;
    idx = 0;
    cyc = 0;
    @(negedge clk);
    a_img   = img[127:0];
    a_start = 1'b1;
    a_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    a_start = 1'b0;
    while (idx < 9 && cyc < 200) begin
      orow = idx / 3;
      ocol = idx % 3;
      check("a_valid", 256'(a_valid), 256'(1));
      check("a_busy", 256'(a_busy), 256'(1));
      check("a_done_mid", 256'(a_done), 256'(0));
      check("a_row", 256'(a_row), 256'(orow));
      check("a_col", 256'(a_col), 256'(ocol));
      check("a_last", 256'(a_last), 256'(idx == 8));
      check("a_data", 256'(a_data), model_win(img, 1, 2, 1, 0, orow, ocol));
      if (known && idx == 0) check("a_first", 256'(a_data), 256'(32'h06050201));
      if (known && idx == 1) check("a_second", 256'(a_data), 256'(32'h07060302));
      if (known && idx == 8) check("a_final", 256'(a_data), 256'(32'h100f0c0b));
      // Input image is free to change after capture.
      a_img   = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_start = 1'b0;
      if (mid_start && idx == 4) begin
        a_start = 1'b1;
        a_img   = ~img[127:0];
      end
      a_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    a_start = 1'b0;
    check("a_frame_len", 256'(idx), 256'(9));
    check("a_done", 256'(a_done), 256'(1));
    check("a_valid_done", 256'(a_valid), 256'(0));
    check("a_busy_done", 256'(a_busy), 256'(0));
    @(negedge clk);
    check("a_done_once", 256'(a_done), 256'(0));
    check("a_valid_idle", 256'(a_valid), 256'(0));
    check("a_busy_idle", 256'(a_busy), 256'(0));
  endtask

  logic [1023:0] img_seq;
  logic [1023:0] img_rnd;
  logic [1023:0] img_two;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    a_start = 0; a_ready = 0; a_img = '0;
    b_start = 0; b_ready = 0; b_img = '0;
    c_start = 0; c_ready = 0; c_img = '0;
    img_seq = make_img(1);
    img_rnd = '0;
    img_rnd[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    img_two = make_img(1) | (make_img(101) << 128);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_valid", 256'(a_valid), 256'(0));
    check("rst_a_busy", 256'(a_busy), 256'(0));
    check("rst_a_done", 256'(a_done), 256'(0));
    check("rst_a_data", 256'(a_data), 256'(0));
    check("rst_a_rowcol", 256'({a_row, a_col}), 256'(0));
    check("rst_a_last", 256'(a_last), 256'(0));
    check("rst_b_valid", 256'(b_valid), 256'(0));
    check("rst_c_valid", 256'(c_valid), 256'(0));
    rst = 1'b0;

    // Ready asserted while idle must do nothing.
    a_ready = 1'b1;
    @(negedge clk);
    check("idle_ready", 256'(a_valid), 256'(0));

    run_a(img_seq, 1'b0, 1'b0, 1'b1);
    run_a(img_seq, 1'b1, 1'b0, 1'b1);
    run_a(img_rnd, 1'b1, 1'b0, 1'b0);
    run_a(img_seq, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a frame, while window 4 is on the output.
    a_img   = img_seq[127:0];
    a_start = 1'b1;
    a_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_row", 256'(a_row), 256'(1));
    check("pre_rst_col", 256'(a_col), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 256'(a_valid), 256'(0));
    check("mid_rst_busy", 256'(a_busy), 256'(0));
    check("mid_rst_done", 256'(a_done), 256'(0));
    check("mid_rst_rowcol", 256'({a_row, a_col}), 256'(0));
    run_a(img_seq, 1'b0, 1'b0, 1'b1);

    // Padded, strided configuration.
    b_img   = img_seq[127:0];
    b_start = 1'b1;
    b_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int idx = 0; idx < 4; idx++) begin
      check("b_valid", 256'(b_valid), 256'(1));
      check("b_row", 256'(b_row), 256'(idx / 2));
      check("b_col", 256'(b_col), 256'(idx % 2));
      check("b_last", 256'(b_last), 256'(idx == 3));
      check("b_data", 256'(b_data), model_win(img_seq, 1, 3, 2, 1, idx / 2, idx % 2));
      if (idx == 0) check("b_first", 256'(b_data), 256'(72'h06_05_00_02_01_00_00_00_00));
      if (idx == 3) check("b_final", 256'(b_data), 256'(72'h10_0f_0e_0c_0b_0a_08_07_06));
      @(negedge clk);
    end
    check("b_done", 256'(b_done), 256'(1));
    @(negedge clk);
    check("b_done_once", 256'(b_done), 256'(0));

    // Two-channel configuration.
    c_img   = img_two[255:0];
    c_start = 1'b1;
    c_ready = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    for (int idx = 0; idx < 9; idx++) begin
      check("c_valid", 256'(c_valid), 256'(1));
      check("c_rowcol", 256'({c_row, c_col}), 256'({2'(idx / 3), 2'(idx % 3)}));
      check("c_last", 256'(c_last), 256'(idx == 8));
      check("c_data", 256'(c_data), model_win(img_two, 2, 2, 1, 0, idx / 3, idx % 3));
      if (idx == 0) check("c_first", 256'(c_data), 256'(64'h6a_69_66_65_06_05_02_01));
      @(negedge clk);
    end
    check("c_done", 256'(c_done), 256'(1));
    @(negedge clk);
    check("c_done_once", 256'(c_done), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_stream_mc.md
# window_stream_mc

Multi-channel sliding-window generator for the convolution datapath: the successor to the single-channel window slider. It latches a flattened CHANNELS×IMG_H×IMG_W image on `start` and emits every K_H×K_W window, across all channels, in raster order. Windows honour stride and optional zero padding. Output is a valid/ready stream, so the downstream MAC array can apply back-pressure, and each window carries its output coordinates.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per pixel
- CHANNELS, 1: input channels, all emitted together in one window beat
- IMG_H, 4 / IMG_W, 4: image height/width
- K_H, 2 / K_W, 2: kernel height/width
- STRIDE_H, 1 / STRIDE_W, 1: vertical/horizontal stride, ≥1
- PAD, 0: zero-padding pixels on every border
- Derived: OUT_H = (IMG_H+2·PAD−K_H)/STRIDE_H+1 and OUT_W = (IMG_W+2·PAD−K_W)/STRIDE_W+1 (integer division). Elaboration error if either is <1.

Ports:
- clk, in, 1: clock, rising edge
- rst, in, 1: synchronous, active-high reset
- start, in, 1: capture `image_flat` and begin a frame; honoured only in IDLE
- image_flat, in, DATA_WIDTH·CHANNELS·IMG_H·IMG_W: pixel (c,r,x) at bit index ((c·IMG_H+r)·IMG_W+x)·DATA_WIDTH
- win_ready, in, 1: downstream accepts the current window
- win_data, out, DATA_WIDTH·CHANNELS·K_H·K_W: element (c,kr,kc) at ((c·K_H+kr)·K_W+kc)·DATA_WIDTH
- win_valid, out, 1: `win_data`, `win_row`, `win_col`, `win_last` are valid
- win_row, out, $clog2(OUT_H) (min 1): output row of the current window
- win_col, out, $clog2(OUT_W) (min 1): output column of the current window
- win_last, out, 1: current window is the final one, (OUT_H−1, OUT_W−1)
- busy, out, 1: frame in progress
- done, out, 1: one-cycle pulse after the last window is accepted

## Operation
- FSM states are IDLE → EMIT → DONE → IDLE.
- IDLE
  - All outputs are 0.
  - When `start`=1: register `image_flat` into an internal frame buffer, clear the row/column counters, go to EMIT.
- EMIT
  - `win_valid`=1 and `busy`=1.
  - `win_data` is gathered from the frame buffer, not from `image_flat`, so the input may change freely after capture.
  - Source pixel for (c,kr,kc) is at row = win_row·STRIDE_H+kr−PAD and col = win_col·STRIDE_W+kc−PAD.
  - If row∉[0,IMG_H) or col∉[0,IMG_W), the element is 0.
  - Handshake: a beat transfers when `win_valid && win_ready`. Without a transfer, all window outputs hold stable.
  - On transfer, advance in raster order: col+1. At col=OUT_W−1, wrap col to 0 and row+1.
  - Transfer with `win_last`=1 → go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, `win_valid`=0, then IDLE.
- `start` in EMIT or DONE is ignored; the frame buffer is not re-captured.
- Reset in any state → IDLE next edge, all outputs 0, counters 0. A partial frame is discarded with no `done`.
- Arithmetic: coordinate math uses signed intermediates wide enough for −PAD to IMG+PAD. Counter width is per the port widths.

## Timing
- Reset value of every output is 0.
- `start` sampled high at edge N → `win_valid`=1 with window (0,0) after edge N (visible in cycle N+1). Latency is 1.
- Window output registers are updated on the same edge as the counter advance. With `win_ready` held high, one window is emitted per cycle and a frame takes OUT_H·OUT_W cycles plus 1 DONE cycle.
- Last transfer at edge M → `done`=1 during cycle M+1. A new `start` is accepted from edge M+2 (IDLE).
- `win_ready` may be asserted before `win_valid`; it has no effect in IDLE/DONE.

## Structure
- Package `window_pkg`:
  - state enum (IDLE/EMIT/DONE)
  - functions `out_dim(img,k,stride,pad)` and `clog2_min1(x)`
  - function for flat bit-index computation of image and window elements
- Sub-module `window_gather` (combinational): frame buffer + row/col → `win_data` with zero-padding muxes, one generate instance per (c,kr,kc). Its output feeds the registered window outputs in the top.
- Top holds the FSM, counters, frame buffer and handshake.

## Test plan
- Default params, image 1..16, `win_ready`=1 → 9 windows:
  - first {1,2,5,6}, second {2,3,6,7}
  - last {11,12,15,16} with `win_last`=1 at (2,2)
  - `done` one cycle after that window.
- Same frame, `win_ready` toggled 1-0-0-1 pseudo-randomly → identical 9-window sequence, with outputs stable during every stall cycle.
- K=3, STRIDE=2, PAD=1, image 1..16 → 2×2 output:
  - (0,0) = {0,0,0, 0,1,2, 0,5,6}
  - (1,1) = {6,7,8, 10,11,12, 14,15,16}
- CHANNELS=2, ch0 = 1..16, ch1 = 101..116, defaults → first window {1,2,5,6,101,102,105,106}.
- Assert `start` with a different image mid-frame → ignored; output still matches the first image; no extra `done`.
- Assert `rst` at window 4 → next cycle `win_valid`/`busy`/`done` all 0. A subsequent `start` restarts from (0,0).
